// File: rtl/quiz_answer_arbiter.sv
// Quiz answer arbiter: synchronises and debounces keypads, arbitrates
// answers per round, judges them and keeps saturating per-player scores.
// Ports:
//   clk, rst (sync, active-high)
//   btn_n[K]      raw active-low keys, player 1 choice 1 at the MSB
//   round_start   opens a round, prob_ans latched at that moment
//   score_clr     zeros every score on the next edge
//   round_active  round open (ARMED/JUDGE)
//   ans_valid     one-cycle pulse per judged answer (player/choice/correct)
//   winner        player credited this round, 0 = none
//   locked        per-player lockout, bit p-1 = player p
//   scores        player p at [p*SCORE_W-1 -: SCORE_W]
module quiz_answer_arbiter #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_CHOICES = 4,
    parameter int SCORE_W     = 4,
    parameter int DEBOUNCE    = 3,
    parameter int TIMEOUT     = 1000,
    localparam int K  = NUM_PLAYERS * NUM_CHOICES,
    localparam int CW = $clog2(NUM_CHOICES + 1),
    localparam int PW = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [K-1:0]                   btn_n,
    input  logic                           round_start,
    input  logic [CW-1:0]                  prob_ans,
    input  logic                           score_clr,
    output logic                           round_active,
    output logic                           ans_valid,
    output logic [PW-1:0]                  ans_player,
    output logic [CW-1:0]                  ans_choice,
    output logic                           ans_correct,
    output logic [PW-1:0]                  winner,
    output logic [NUM_PLAYERS-1:0]         locked,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_JUDGE,
        S_DONE
    } state_t;

    logic [K-1:0]                   sync1_q, sync2_q, prev_q;
    logic [DW-1:0]                  cnt_q, cnt_d;
    logic                           armed_q, armed_d;
    state_t                         state_q, state_d;
    logic [CW-1:0]                  prob_q, prob_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic [NUM_PLAYERS-1:0]         locked_q, locked_d;
    logic [PW-1:0]                  winner_q, winner_d;
    logic                           ans_valid_q, ans_valid_d;
    logic [PW-1:0]                  ans_player_q, ans_player_d;
    logic [CW-1:0]                  ans_choice_q, ans_choice_d;
    logic                           ans_correct_q, ans_correct_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;

    logic                           code_ok;
    logic                           ev_fire;
    logic                           ev_locked;
    logic [PW-1:0]                  ev_player;
    logic [CW-1:0]                  ev_choice;
    logic [NUM_PLAYERS-1:0]         judge_onehot;
    logic                           inc;

    // Key decode: exactly one low bit forms a valid code.
    always_comb begin
        code_ok   = ($countones(~sync2_q) == 1);
        ev_player = '0;
        ev_choice = '0;
        ev_locked = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int c = 0; c < NUM_CHOICES; c++) begin
                if (!sync2_q[K-1-(p*NUM_CHOICES+c)]) begin
                    ev_player = PW'(p + 1);
                    ev_choice = CW'(c + 1);
                    ev_locked = locked_q[p];
                end
            end
        end
    end

    // Debounce: counter saturates once the event point is reached; the
    // armed flag blocks repeats until the pad returns to all-ones.
    always_comb begin
        if (code_ok && (sync2_q == prev_q)) begin
            cnt_d = (cnt_q == DW'(DEBOUNCE - 1)) ? cnt_q : cnt_q + DW'(1);
        end else begin
            cnt_d = '0;
        end
        ev_fire = code_ok && armed_q && (cnt_d == DW'(DEBOUNCE - 1));
        if (&sync2_q) begin
            armed_d = 1'b1;
        end else if (ev_fire) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    always_comb begin
        judge_onehot = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            judge_onehot[p] = (ans_player_q == PW'(p + 1));
        end
    end

    always_comb begin
        state_d       = state_q;
        prob_d        = prob_q;
        timer_d       = timer_q;
        locked_d      = locked_q;
        winner_d      = winner_q;
        ans_valid_d   = 1'b0;
        ans_player_d  = ans_player_q;
        ans_choice_d  = ans_choice_q;
        ans_correct_d = ans_correct_q;
        inc           = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (round_start) begin
                    prob_d   = prob_ans;
                    locked_d = '0;
                    winner_d = '0;
                    timer_d  = '0;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q
                                                    : timer_q + TW'(1);
                if (ev_fire && !ev_locked) begin
                    state_d       = S_JUDGE;
                    ans_valid_d   = 1'b1;
                    ans_player_d  = ev_player;
                    ans_choice_d  = ev_choice;
                    // out-of-range prob never matches a 1..N choice
                    ans_correct_d = (ev_choice == prob_q);
                end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                    state_d  = S_DONE;
                    winner_d = '0;
                end
            end
            S_JUDGE: begin
                timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q
                                                    : timer_q + TW'(1);
                if (ans_correct_q) begin
                    winner_d = ans_player_q;
                    inc      = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    locked_d = locked_q | judge_onehot;
                    state_d  = (&locked_d) ? S_DONE : S_ARMED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scores_d = scores_q;
        if (score_clr) begin
            scores_d = '0;
        end else if (inc) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (judge_onehot[p] && (scores_q[p*SCORE_W +: SCORE_W] != '1)) begin
                    scores_d[p*SCORE_W +: SCORE_W] =
                        scores_q[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            armed_q       <= 1'b1;
            state_q       <= S_IDLE;
            prob_q        <= '0;
            timer_q       <= '0;
            locked_q      <= '0;
            winner_q      <= '0;
            ans_valid_q   <= 1'b0;
            ans_player_q  <= '0;
            ans_choice_q  <= '0;
            ans_correct_q <= 1'b0;
            scores_q      <= '0;
        end else begin
            sync1_q       <= btn_n;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            prob_q        <= prob_d;
            timer_q       <= timer_d;
            locked_q      <= locked_d;
            winner_q      <= winner_d;
            ans_valid_q   <= ans_valid_d;
            ans_player_q  <= ans_player_d;
            ans_choice_q  <= ans_choice_d;
            ans_correct_q <= ans_correct_d;
            scores_q      <= scores_d;
        end
    end

    assign round_active = (state_q == S_ARMED) || (state_q == S_JUDGE);
    assign ans_valid    = ans_valid_q;
    assign ans_player   = ans_player_q;
    assign ans_choice   = ans_choice_q;
    assign ans_correct  = ans_correct_q;
    assign winner       = winner_q;
    assign locked       = locked_q;
    assign scores       = scores_q;

endmodule
